snn_param_mem: RTL and testbench

SNN_PARAM_MEM -- requirements
Module: snn_param_mem

---
 rtl/snn_param_mem_if.sv | 34 +++
 rtl/snn_param_mem.sv | 77 +++++++
 tb/tb_snn_param_mem.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/snn_param_mem_if.sv
// Host-side bus for the SNN parameter memory: random access, streaming load,
// commit/clear control and the read-back outputs.
interface snn_param_mem_if #(
    parameter int M  = 320,
    parameter int N  = 8,
    parameter int AW = 9
);
    logic [N-1:0]   data_in;
    logic [AW-1:0]  addr;
    logic           write_enable;
    logic           stream_start;
    logic           stream_valid;
    logic [N-1:0]   stream_data;
    logic           commit;
    logic           clear;
    logic [N-1:0]   data_out;
    logic [M*N-1:0] all_data_out;
    logic [AW-1:0]  wr_ptr;
    logic           stream_done;
    logic           pending;
    logic           addr_err;

    modport master (
        output data_in, addr, write_enable, stream_start, stream_valid,
               stream_data, commit, clear,
        input  data_out, all_data_out, wr_ptr, stream_done, pending, addr_err
    );

    modport slave (
        input  data_in, addr, write_enable, stream_start, stream_valid,
               stream_data, commit, clear,
        output data_out, all_data_out, wr_ptr, stream_done, pending, addr_err
    );
endinterface

// File: rtl/snn_param_mem.sv
// Double-banked parameter store: a working bank written randomly or by stream,
// and a shadow bank that snapshots the working bank on commit.
module snn_param_mem #(
    parameter int M  = 320,
    parameter int N  = 8,
    parameter int AW = 9
) (
    input  logic           clk,
    input  logic           reset,
    snn_param_mem_if.slave bus
);
    localparam logic [AW-1:0] LAST = AW'(M - 1);

    logic [M-1:0][N-1:0] work;
    logic [M-1:0][N-1:0] shadow;
    logic [AW-1:0]       ptr;
    logic                done;
    logic                dirty;
    logic                err;
    logic                in_range;

    assign in_range = (int'({1'b0, bus.addr}) < M);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work   <= '0;
            shadow <= '0;
            ptr    <= '0;
            done   <= 1'b0;
            dirty  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            // Commit samples pre-edge contents; a same-cycle write re-dirties below.
            if (bus.commit) begin
                shadow <= work;
                dirty  <= 1'b0;
            end
            if (bus.clear) begin
                work  <= '0;
                ptr   <= '0;
                err   <= 1'b0;
                dirty <= 1'b1;
            end else if (bus.stream_start) begin
                if (in_range) begin
                    ptr <= bus.addr;
                end else begin
                    ptr <= '0;
                    err <= 1'b1;
                end
            end else if (bus.write_enable) begin
                if (in_range) begin
                    work[bus.addr] <= bus.data_in;
                    dirty          <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (bus.stream_valid) begin
                work[ptr] <= bus.stream_data;
                dirty     <= 1'b1;
                if (ptr == LAST) begin
                    ptr  <= '0;
                    done <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

    assign bus.data_out     = in_range ? work[bus.addr] : '0;
    assign bus.all_data_out = shadow;
    assign bus.wr_ptr       = ptr;
    assign bus.stream_done  = done;
    assign bus.pending      = dirty;
    assign bus.addr_err     = err;
endmodule

// File: tb/tb_snn_param_mem.sv
// Directed checks of snn_param_mem: random write/commit, stream wrap,
// priority collisions, out-of-range handling, commit+write and reset mid-stream.
module tb_snn_param_mem;
    localparam int M  = 320;
    localparam int N  = 8;
    localparam int AW = 9;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    snn_param_mem_if #(.M(M), .N(N), .AW(AW)) bus ();

    snn_param_mem #(.M(M), .N(N), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.data_in      = '0;
        bus.write_enable = 1'b0;
        bus.stream_start = 1'b0;
        bus.stream_valid = 1'b0;
        bus.stream_data  = '0;
        bus.commit       = 1'b0;
        bus.clear        = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.addr = '0;
        reset = 1'b1;
        #12;
        nvec++; if (bus.wr_ptr !== 9'd0) begin nerr++; $display("FAIL reset_wr_ptr got %0d want 0", bus.wr_ptr); end
        nvec++; if (bus.pending !== 1'b0) begin nerr++; $display("FAIL reset_pending got %b want 0", bus.pending); end
        nvec++; if (bus.addr_err !== 1'b0) begin nerr++; $display("FAIL reset_addr_err got %b want 0", bus.addr_err); end
        nvec++; if (bus.stream_done !== 1'b0) begin nerr++; $display("FAIL reset_stream_done got %b want 0", bus.stream_done); end
        nvec++; if (bus.all_data_out !== '0) begin nerr++; $display("FAIL reset_shadow got nonzero want 0"); end
        reset = 1'b0;
        tick();
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
    endtask

    task automatic test_write_commit();
        bus.addr = 9'd5; bus.data_in = 8'hA5; bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
        #1;
        nvec++; if (bus.data_out !== 8'hA5) begin nerr++; $display("FAIL wr_data_out got %h want a5", bus.data_out); end
        nvec++; if (bus.pending !== 1'b1) begin nerr++; $display("FAIL wr_pending got %b want 1", bus.pending); end
        nvec++; if (bus.all_data_out[47:40] !== 8'h00) begin nerr++; $display("FAIL wr_shadow_pre got %h want 00", bus.all_data_out[47:40]); end
        tick();
        nvec++; if (bus.all_data_out[47:40] !== 8'h00) begin nerr++; $display("FAIL wr_shadow_idle got %h want 00", bus.all_data_out[47:40]); end
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        nvec++; if (bus.all_data_out[47:40] !== 8'hA5) begin nerr++; $display("FAIL commit_shadow got %h want a5", bus.all_data_out[47:40]); end
        nvec++; if (bus.pending !== 1'b0) begin nerr++; $display("FAIL commit_pending got %b want 0", bus.pending); end
    endtask

    task automatic test_stream_wrap();
        bus.addr = 9'd318; bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        nvec++; if (bus.wr_ptr !== 9'd318) begin nerr++; $display("FAIL sw_start_ptr got %0d want 318", bus.wr_ptr); end
        bus.stream_valid = 1'b1; bus.stream_data = 8'h11;
        tick();
        nvec++; if (bus.stream_done !== 1'b0) begin nerr++; $display("FAIL sw_done_early got %b want 0", bus.stream_done); end
        bus.stream_data = 8'h22;
        tick();
        nvec++; if (bus.stream_done !== 1'b1) begin nerr++; $display("FAIL sw_done got %b want 1", bus.stream_done); end
        nvec++; if (bus.wr_ptr !== 9'd0) begin nerr++; $display("FAIL sw_wrap_ptr got %0d want 0", bus.wr_ptr); end
        bus.stream_data = 8'h33;
        tick();
        bus.stream_valid = 1'b0;
        nvec++; if (bus.stream_done !== 1'b0) begin nerr++; $display("FAIL sw_done_late got %b want 0", bus.stream_done); end
        nvec++; if (bus.wr_ptr !== 9'd1) begin nerr++; $display("FAIL sw_end_ptr got %0d want 1", bus.wr_ptr); end
        bus.addr = 9'd318; #1;
        nvec++; if (bus.data_out !== 8'h11) begin nerr++; $display("FAIL sw_w318 got %h want 11", bus.data_out); end
        bus.addr = 9'd319; #1;
        nvec++; if (bus.data_out !== 8'h22) begin nerr++; $display("FAIL sw_w319 got %h want 22", bus.data_out); end
        bus.addr = 9'd0; #1;
        nvec++; if (bus.data_out !== 8'h33) begin nerr++; $display("FAIL sw_w0 got %h want 33", bus.data_out); end
    endtask

    task automatic test_collision();
        bus.addr = 9'd3; bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        bus.addr = 9'd10; bus.data_in = 8'h7E; bus.write_enable = 1'b1;
        bus.stream_valid = 1'b1; bus.stream_data = 8'h55;
        tick();
        idle();
        nvec++; if (bus.wr_ptr !== 9'd3) begin nerr++; $display("FAIL col_ptr got %0d want 3", bus.wr_ptr); end
        #1;
        nvec++; if (bus.data_out !== 8'h7E) begin nerr++; $display("FAIL col_w10 got %h want 7e", bus.data_out); end
        bus.addr = 9'd3; #1;
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL col_w3 got %h want 00", bus.data_out); end
        // stream_start outranks write_enable: the write must be dropped
        bus.addr = 9'd12; bus.stream_start = 1'b1; bus.write_enable = 1'b1; bus.data_in = 8'h99;
        tick();
        idle();
        nvec++; if (bus.wr_ptr !== 9'd12) begin nerr++; $display("FAIL col_ss_ptr got %0d want 12", bus.wr_ptr); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL col_ss_w12 got %h want 00", bus.data_out); end
    endtask

    task automatic test_out_of_range();
        bus.addr = 9'd400; bus.data_in = 8'hFF; bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
        nvec++; if (bus.addr_err !== 1'b1) begin nerr++; $display("FAIL oor_err got %b want 1", bus.addr_err); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL oor_data_out got %h want 00", bus.data_out); end
        bus.addr = 9'd10; #1;
        nvec++; if (bus.data_out !== 8'h7E) begin nerr++; $display("FAIL oor_w10 got %h want 7e", bus.data_out); end
        bus.addr = 9'd320; bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        nvec++; if (bus.wr_ptr !== 9'd0) begin nerr++; $display("FAIL oor_ss_ptr got %0d want 0", bus.wr_ptr); end
        tick();
        nvec++; if (bus.addr_err !== 1'b1) begin nerr++; $display("FAIL oor_sticky got %b want 1", bus.addr_err); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        nvec++; if (bus.addr_err !== 1'b0) begin nerr++; $display("FAIL clr_err got %b want 0", bus.addr_err); end
        nvec++; if (bus.pending !== 1'b1) begin nerr++; $display("FAIL clr_pending got %b want 1", bus.pending); end
        bus.addr = 9'd10; #1;
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL clr_w10 got %h want 00", bus.data_out); end
        bus.addr = 9'd318; #1;
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL clr_w318 got %h want 00", bus.data_out); end
        nvec++; if (bus.all_data_out[47:40] !== 8'hA5) begin nerr++; $display("FAIL clr_shadow got %h want a5", bus.all_data_out[47:40]); end
    endtask

    task automatic test_commit_write();
        bus.addr = 9'd7; bus.data_in = 8'h01; bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0; bus.commit = 1'b1;
        tick();
        bus.data_in = 8'h02; bus.write_enable = 1'b1; bus.commit = 1'b1;
        tick();
        idle();
        nvec++; if (bus.all_data_out[63:56] !== 8'h01) begin nerr++; $display("FAIL cw_shadow got %h want 01", bus.all_data_out[63:56]); end
        nvec++; if (bus.data_out !== 8'h02) begin nerr++; $display("FAIL cw_work got %h want 02", bus.data_out); end
        nvec++; if (bus.pending !== 1'b1) begin nerr++; $display("FAIL cw_pending got %b want 1", bus.pending); end
    endtask

    task automatic test_reset_midstream();
        bus.addr = 9'd0; bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        bus.stream_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.stream_data = 8'(8'h40 + i);
            tick();
        end
        nvec++; if (bus.wr_ptr !== 9'd4) begin nerr++; $display("FAIL rm_ptr_pre got %0d want 4", bus.wr_ptr); end
        reset = 1'b1;
        #2;
        nvec++; if (bus.wr_ptr !== 9'd0) begin nerr++; $display("FAIL rm_ptr got %0d want 0", bus.wr_ptr); end
        nvec++; if (bus.pending !== 1'b0) begin nerr++; $display("FAIL rm_pending got %b want 0", bus.pending); end
        nvec++; if (bus.all_data_out !== '0) begin nerr++; $display("FAIL rm_shadow got nonzero want 0"); end
        bus.addr = 9'd2; #1;
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL rm_data_out got %h want 00", bus.data_out); end
        idle();
        reset = 1'b0;
        tick();
        nvec++; if (bus.wr_ptr !== 9'd0) begin nerr++; $display("FAIL rm_ptr_post got %0d want 0", bus.wr_ptr); end
        nvec++; if (bus.stream_done !== 1'b0) begin nerr++; $display("FAIL rm_done got %b want 0", bus.stream_done); end
        nvec++; if (bus.addr_err !== 1'b0) begin nerr++; $display("FAIL rm_err got %b want 0", bus.addr_err); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b0;
        test_reset();
        test_write_commit();
        test_stream_wrap();
        test_collision();
        test_out_of_range();
        test_commit_write();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
